shift_sipo_word: RTL and testbench
==================================

# shift_sipo_word

Parametrised serial-in/parallel-out deserialiser, successor to the fixed 4-bit SIPO shifter. It collects WIDTH serial bits under a bit-enable, selects LSB-first or MSB-first ordering, and tracks word position with a bit counter. Each completed word is presented on a valid/ready output port backed by a one-word holding register; a sticky overrun flag reports words dropped on back-pressure. It sits between a serial link front end and word-oriented consumers such as a FIFO or decoder.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- LSB_FIRST, 1, bit order. 1: first received bit lands in bit 0, shifting right as the 4-bit SIPO does. 0: first received bit lands in bit WIDTH-1, shifting left.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_in  in  1  serial data bit.
- s_en  in  1  bit strobe; s_in is sampled only when s_en=1.
- clr  in  1  synchronous clear of the partial word and the overrun flag.
- q_par  out  WIDTH  live shift-register contents.
- bit_cnt  out  CW  bits held in the current partial word, 0..WIDTH-1; CW = clog2(WIDTH).
- out_data  out  WIDTH  completed word in the holding register.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- overrun  out  1  sticky flag: a completed word was dropped.

## Operation
- Reset: q_par=0, bit_cnt=0, out_data=0, out_valid=0, overrun=0.
- Per-cycle priority: clr, then s_en.
- clr=1: shift register and bit_cnt go to 0, overrun goes to 0, s_en is ignored. out_data and out_valid are unaffected, and an accept (out_valid & out_ready) still completes.
- s_en=1 with clr=0:
  - LSB_FIRST=1: sh_next = {s_in, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh_next = {sh[WIDTH-2:0], s_in}.
  - If bit_cnt < WIDTH-1, bit_cnt increments.
  - If bit_cnt = WIDTH-1, the word completes: bit_cnt wraps to 0 and sh_next is the completed word.
- Completed word, holding register free (out_valid=0, or out_valid & out_ready in the same cycle): out_data <= sh_next, out_valid <= 1.
- Completed word, holding register full and not being accepted: the word is discarded, out_data is held, out_valid stays 1, overrun <= 1.
- Accept with no simultaneous completion: out_valid <= 0; out_data keeps its value.
- s_en=0: shift register and bit_cnt hold.
- The shift register is not cleared at word completion. It continues shifting, so q_par always shows the last WIDTH bits received.
- overrun clears only on rst or clr.

## Timing
- The bit sampled at edge k appears on q_par after edge k.
- Word latency: out_valid rises after the same edge that samples bit WIDTH-1, so out_data is visible 0 cycles after the last q_par update.
- Back-to-back words at 1 bit/cycle are sustained with out_ready held at 1. The holding register frees and reloads in the same cycle.
- Reset asserted mid-word: everything returns to reset values immediately and asynchronously. The partial word is lost and no out_valid is produced.
- out_valid, out_data and overrun are registered outputs with no combinational path from inputs. q_par and bit_cnt are also registered.

## Structure
- Shared package shift_pkg holds:
  - the default constants SHIFT_WIDTH_DEF=8 and SHIFT_LSB_FIRST_DEF=1;
  - a clog2 helper function, shared with other counters in the serial family.
- One sub-module, shift_core: parametrised WIDTH/LSB_FIRST shifter with async reset, enable and sync clear, exposing its register as q.
- The top level adds the bit counter, the holding register with valid/ready, and the overrun logic.

## Test plan
All scenarios use WIDTH=8 unless stated.
- Basic capture, LSB_FIRST=1, out_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles with s_en=1 -> out_data=0xA5, out_valid high for exactly 1 cycle after bit 8, bit_cnt returns to 0.
- Bit order, LSB_FIRST=0: same bit sequence -> out_data=0xA5 reversed = 0xA5 is symmetric, so use bits 1,1,0,0,0,0,0,0 instead -> out_data=0xC0; with LSB_FIRST=1 the same sequence gives 0x03.
- Gapped strobe: 0x3C sent LSB-first with s_en low for 2 cycles between every bit -> out_data=0x3C, and bit_cnt holds during the gaps.
- Back-pressure and overrun, out_ready=0: send 0x11, then 0x22 -> out_data stays 0x11 and overrun=1. Then pulse out_ready -> out_valid=0. Then pulse clr -> overrun=0.
- Simultaneous accept and completion: out_valid=1 holding 0x11, out_ready=1 on the cycle bit 8 of 0x22 arrives -> out_data=0x22, out_valid stays 1, overrun=0.
- Reset/clear mid-word: after 5 bits, assert rst asynchronously between edges -> all outputs 0 immediately. Repeat with clr instead -> bit_cnt=0 and q_par=0, out_valid unchanged, and the next 8 bits form a clean word.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and helpers for the serial shifter family.
package shift_pkg;

    localparam int SHIFT_WIDTH_DEF     = 8;
    localparam int SHIFT_LSB_FIRST_DEF = 1;

    // Ceiling log2, never below 1 so that a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_sipo_word_if.sv
// Serial input strobe plus word output valid/ready port of the SIPO deserialiser.
interface shift_sipo_word_if #(
    parameter int WIDTH = shift_pkg::SHIFT_WIDTH_DEF
);
    localparam int CW = shift_pkg::clog2(WIDTH);

    logic             s_in;
    logic             s_en;
    logic             clr;
    logic [WIDTH-1:0] q_par;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    modport master (
        output s_in, s_en, clr, out_ready,
        input  q_par, bit_cnt, out_data, out_valid, overrun
    );

    modport slave (
        input  s_in, s_en, clr, out_ready,
        output q_par, bit_cnt, out_data, out_valid, overrun
    );

endinterface

// File: rtl/shift_core.sv
// Parametrised shift register with enable and sync clear; exposes the next value
// so the caller can capture a completing word in the same cycle.
module shift_core #(
    parameter int WIDTH     = shift_pkg::SHIFT_WIDTH_DEF,
    parameter int LSB_FIRST = shift_pkg::SHIFT_LSB_FIRST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shifted
);

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign shifted = {d, q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {q[WIDTH-2:0], d};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= shifted;
    end

endmodule

// File: rtl/shift_sipo_word.sv
// Serial-in/parallel-out deserialiser: bit counter, one-word holding register
// with valid/ready, and sticky overrun on dropped words.
module shift_sipo_word
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_WIDTH_DEF,
    parameter int LSB_FIRST = SHIFT_LSB_FIRST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    shift_sipo_word_if.slave   bus
);

    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             vld;
    logic             ovr;
    logic             step;
    logic             done;
    logic             accept;
    logic             hold_free;

    shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.s_en),
        .clr     (bus.clr),
        .d       (bus.s_in),
        .q       (sh),
        .shifted (sh_nxt)
    );

    assign step      = bus.s_en & ~bus.clr;
    assign done      = step & (cnt == CW'(WIDTH - 1));
    assign accept    = vld & bus.out_ready;
    assign hold_free = ~vld | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (bus.clr) cnt <= '0;
        else if (done) cnt <= '0;
        else if (step) cnt <= cnt + CW'(1);
    end

    // clr never blocks the output side: an accept in a clr cycle still retires the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            vld  <= 1'b0;
        end else if (done && hold_free) begin
            hold <= sh_nxt;
            vld  <= 1'b1;
        end else if (accept) begin
            vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   ovr <= 1'b0;
        else if (bus.clr)          ovr <= 1'b0;
        else if (done && !hold_free) ovr <= 1'b1;
    end

    assign bus.q_par     = sh;
    assign bus.bit_cnt   = cnt;
    assign bus.out_data  = hold;
    assign bus.out_valid = vld;
    assign bus.overrun   = ovr;

endmodule

// File: tb/tb_shift_sipo_word.sv
// Directed bench for shift_sipo_word: vector table plus multi-cycle corner sequences.
module tb_shift_sipo_word;

    logic clk;
    logic rst;
    logic s_in, s_en, clr, out_ready;
    int   n_cmp;
    int   n_err;

    shift_sipo_word_if #(.WIDTH(8)) bus0 ();
    shift_sipo_word_if #(.WIDTH(8)) bus1 ();

    assign bus0.s_in = s_in;  assign bus0.s_en = s_en;
    assign bus0.clr  = clr;   assign bus0.out_ready = out_ready;
    assign bus1.s_in = s_in;  assign bus1.s_en = s_en;
    assign bus1.clr  = clr;   assign bus1.out_ready = out_ready;

    shift_sipo_word #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    shift_sipo_word #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, din, c, rdy;
        logic [7:0] q;
        logic [2:0] cnt;
        logic [7:0] od;
        logic       ov_v;
        logic       ov;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step the clock, sample 1 time unit after the edge.
    task automatic tick(input logic en, input logic din, input logic c, input logic rdy);
        s_en = en; s_in = din; clr = c; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [7:0] q, input logic [2:0] cnt,
                             input logic [7:0] od, input logic vv, input logic ov);
        check({name, ".q_par"},     32'(bus0.q_par),     32'(q));
        check({name, ".bit_cnt"},   32'(bus0.bit_cnt),   32'(cnt));
        check({name, ".out_data"},  32'(bus0.out_data),  32'(od));
        check({name, ".out_valid"}, 32'(bus0.out_valid), 32'(vv));
        check({name, ".overrun"},   32'(bus0.overrun),   32'(ov));
    endtask

    // Send a word LSB-first; gap idle cycles between bits check that bit_cnt holds.
    task automatic send_word(input string name, input logic [7:0] w, input logic rdy,
                             input logic rdy_last, input int gap);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, w[i], 1'b0, (i == 7) ? rdy_last : rdy);
            if (i < 7) begin
                check({name, ".cnt"}, 32'(bus0.bit_cnt), i + 1);
                for (int g = 0; g < gap; g++) begin
                    tick(1'b0, 1'b0, 1'b0, rdy);
                    check({name, ".cnt_gap"}, 32'(bus0.bit_cnt), i + 1);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; s_in = 1'b0; s_en = 1'b0; clr = 1'b0; out_ready = 1'b0;

        //          en din c rdy  q      cnt  od     v  ov
        tbl[0]  = '{1, 1, 0, 1, 8'h80, 3'd1, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 8'h40, 3'd2, 8'h00, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 8'hA0, 3'd3, 8'h00, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 8'h50, 3'd4, 8'h00, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 8'h28, 3'd5, 8'h00, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 8'h94, 3'd6, 8'h00, 0, 0};
        tbl[6]  = '{1, 0, 0, 1, 8'h4A, 3'd7, 8'h00, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 8'hA5, 3'd0, 8'hA5, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 8'hA5, 3'd0, 8'hA5, 0, 0};
        tbl[9]  = '{1, 1, 0, 1, 8'hD2, 3'd1, 8'hA5, 0, 0};
        tbl[10] = '{1, 1, 0, 1, 8'hE9, 3'd2, 8'hA5, 0, 0};
        tbl[11] = '{1, 0, 0, 1, 8'h74, 3'd3, 8'hA5, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 8'h3A, 3'd4, 8'hA5, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 8'h1D, 3'd5, 8'hA5, 0, 0};
        tbl[14] = '{1, 0, 0, 1, 8'h0E, 3'd6, 8'hA5, 0, 0};
        tbl[15] = '{1, 0, 0, 1, 8'h07, 3'd7, 8'hA5, 0, 0};
        tbl[16] = '{1, 0, 0, 1, 8'h03, 3'd0, 8'h03, 1, 0};
        tbl[17] = '{0, 0, 0, 1, 8'h03, 3'd0, 8'h03, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].en, tbl[i].din, tbl[i].c, tbl[i].rdy);
            check_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].cnt, tbl[i].od,
                      tbl[i].ov_v, tbl[i].ov);
        end
        check("msb_first.out_data", 32'(bus1.out_data), 32'h0000_00C0);
        check("msb_first.q_par",    32'(bus1.q_par),    32'h0000_00C0);

        // Gapped strobe
        send_word("gap", 8'h3C, 1'b1, 1'b1, 2);
        check_all("gap_done", 8'h3C, 3'd0, 8'h3C, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("gap_accept.out_valid", 32'(bus0.out_valid), 0);

        // Back-pressure and overrun
        send_word("bp1", 8'h11, 1'b0, 1'b0, 0);
        check_all("bp_first", 8'h11, 3'd0, 8'h11, 1'b1, 1'b0);
        send_word("bp2", 8'h22, 1'b0, 1'b0, 0);
        check_all("bp_drop", 8'h22, 3'd0, 8'h11, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("bp_accept", 8'h22, 3'd0, 8'h11, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("bp_clr", 8'h00, 3'd0, 8'h11, 1'b0, 1'b0);

        // Accept and completion in the same cycle
        send_word("sim1", 8'h11, 1'b0, 1'b0, 0);
        check_all("sim_hold", 8'h11, 3'd0, 8'h11, 1'b1, 1'b0);
        send_word("sim2", 8'h22, 1'b0, 1'b1, 0);
        check_all("sim_swap", 8'h22, 3'd0, 8'h22, 1'b1, 1'b0);

        // Async reset mid-word
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid.cnt", 32'(bus0.bit_cnt), 5);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        check("async_rst.msb_q", 32'(bus1.q_par), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sync clear mid-word, with an unconsumed word held
        send_word("clr1", 8'h5A, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_all("mid_clr", 8'h00, 3'd0, 8'h5A, 1'b1, 1'b0);
        send_word("clr2", 8'h96, 1'b0, 1'b1, 0);
        check_all("post_clr", 8'h96, 3'd0, 8'h96, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
